dibit_word_packer: RTL
======================

# dibit_word_packer

Receive-side counterpart of the team's 2-bit-per-step word shifter. The shifter presents a word two bits per `shift_enable` cycle, least-significant dibit first. This block collects those dibits and rebuilds the full word. It keeps an internal dibit counter that wraps at `WORD_LENGHT/2`, publishes each completed word on a holding register, and pulses `word_valid` for one cycle. It sits directly after the shifter, or after any link carrying its 2-bit stream, in the same clock domain.

## Interface
- `WORD_LENGHT`, default 16: reassembled word width. Must be even and ≥ 4.
- `CNT_W`, default `$clog2(WORD_LENGHT/2)`: dibit counter width. Derived; do not override.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset. Single clock domain.
- `data_in`  in  2  incoming dibit. Sampled only when `shift_enable`=1.
- `shift_enable`  in  1  `data_in` is valid this cycle.
- `synch_reset`  in  1  synchronous flush of a partially assembled word.
- `data_out`  out  `WORD_LENGHT`  last completed word. Held until the next word completes.
- `word_valid`  out  1  one-cycle pulse, concurrent with `data_out` updating.
- `dibit_count`  out  `CNT_W`  number of dibits accepted into the current word.
- `busy`  out  1  high while a partial word is held (state FILLING).

## Operation
- Assembly register `asm`, `WORD_LENGHT` bits, right-shift.
  - On an accepted dibit: `asm <= {data_in, asm[WORD_LENGHT-1:2]}`.
  - After `WORD_LENGHT/2` accepts, dibit k sits in `asm[2k+1:2k]`. This inverts the shifter's `data_in >> 2k`.
- FSM states: EMPTY (reset state) and FILLING.
  - EMPTY + accept → FILLING, `dibit_count`=1.
  - FILLING + accept with `dibit_count` < `WORD_LENGHT/2-1` → increment `dibit_count`.
  - FILLING + accept with `dibit_count` = `WORD_LENGHT/2-1` (last dibit):
    - `data_out <= {data_in, asm[WORD_LENGHT-1:2]}`
    - `word_valid <= 1`
    - `dibit_count <= 0`
    - state → EMPTY
  - No accept: all registers hold, and `word_valid <= 0`.
- `synch_reset`=1 (any state):
  - `asm`, `dibit_count` ← 0; state → EMPTY; `word_valid` ← 0.
  - `data_out` keeps its last completed word.
  - Has priority over a simultaneous `shift_enable`; that dibit is discarded.
- `busy` = (state == FILLING). Registered-state decode, no combinational path from inputs.
- Counter wrap: back-to-back `shift_enable` produces a word every `WORD_LENGHT/2` cycles with no idle gap. A dibit accepted in the cycle after completion starts the next word.
- No overrun detection: the block has no backpressure and accepts every enabled dibit.

## Timing
- Async reset (`reset`=0), effective immediately:
  - `data_out`=0, `word_valid`=0, `dibit_count`=0, `busy`=0, `asm`=0, state EMPTY.
- Release of `reset` is synchronous to the `clk` rising edge; the first accept is possible on the first edge after deassertion.
- Latency: `data_out` and `word_valid` change on the same edge that samples the last dibit. The word is visible one cycle after that dibit is presented.
- `word_valid` is high for exactly one cycle per completed word. It is never high two cycles in a row unless `WORD_LENGHT/2` = 1, which is disallowed.
- `synch_reset` acts on the next edge. `reset` asserted mid-word discards the partial word and clears `data_out`.
- All outputs are registered, with no combinational input-to-output path.

## Test plan
- Reset: hold `reset`=0 and toggle inputs → all outputs 0. Release, then feed nothing → outputs stay 0 and `busy`=0.
- Single word, `WORD_LENGHT`=16: feed dibits 3,0,0,3,1,1,2,2 on consecutive cycles → on the 8th edge `data_out`=0xA5C3, `word_valid`=1 for one cycle, `dibit_count`=0, `busy`=0.
- Gapped enable: same 8 dibits with random `shift_enable` gaps → `data_out`=0xA5C3 appears only after the 8th accept; `dibit_count` holds during gaps.
- Back-to-back words: 16 consecutive dibits encoding 0x1234 then 0xFFFF → `word_valid` pulses on edges 8 and 16; `data_out`=0x1234, then 0xFFFF.
- Flush collision: after 5 dibits, assert `synch_reset` together with `shift_enable` → `dibit_count`=0, `busy`=0, `data_out` unchanged, dibit dropped. The next 8 dibits of 0x00FF then produce `data_out`=0x00FF.
- Mid-word async reset: assert `reset`=0 after 3 dibits, mid-cycle → outputs clear immediately. After release, 8 dibits of 0x5A5A → `data_out`=0x5A5A.

Source files
------------

// File: rtl/dibit_word_packer.sv
// Rebuilds a WORD_LENGHT-bit word from a stream of 2-bit dibits, least-significant dibit first,
// and publishes each completed word on a holding register with a one-cycle valid pulse.
module dibit_word_packer #(
    parameter int WORD_LENGHT = 16,
    parameter int CNT_W       = $clog2(WORD_LENGHT / 2)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             data_in,
    input  logic                   shift_enable,
    input  logic                   synch_reset,
    output logic [WORD_LENGHT-1:0] data_out,
    output logic                   word_valid,
    output logic [CNT_W-1:0]       dibit_count,
    output logic                   busy
);

    typedef enum logic [0:0] {
        ST_EMPTY   = 1'b0,
        ST_FILLING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_LENGHT / 2 - 1);

    state_t                 state_r, state_s;
    logic [WORD_LENGHT-1:0] asm_r, asm_s;
    logic [WORD_LENGHT-1:0] data_out_r, data_out_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic                   valid_r, valid_s;
    logic [WORD_LENGHT-1:0] shifted_s;

    // Next-state and datapath decode; flush wins over a simultaneous dibit.
    always_comb begin
        state_s    = state_r;
        asm_s      = asm_r;
        data_out_s = data_out_r;
        cnt_s      = cnt_r;
        valid_s    = 1'b0;
        shifted_s  = {data_in, asm_r[WORD_LENGHT-1:2]};
        if (synch_reset) begin
            asm_s   = '0;
            cnt_s   = '0;
            state_s = ST_EMPTY;
        end else if (shift_enable) begin
            asm_s = shifted_s;
            case (state_r)
                ST_EMPTY: begin
                    cnt_s   = CNT_W'(1);
                    state_s = ST_FILLING;
                end
                ST_FILLING: begin
                    if (cnt_r == LAST_IDX) begin
                        data_out_s = shifted_s;
                        valid_s    = 1'b1;
                        cnt_s      = '0;
                        state_s    = ST_EMPTY;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    asm_s   = '0;
                    cnt_s   = '0;
                    state_s = ST_EMPTY;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, assembly and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_EMPTY;
            asm_r      <= '0;
            data_out_r <= '0;
            cnt_r      <= '0;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            asm_r      <= asm_s;
            data_out_r <= data_out_s;
            cnt_r      <= cnt_s;
            valid_r    <= valid_s;
        end
    end

    assign data_out    = data_out_r;
    assign word_valid  = valid_r;
    assign dibit_count = cnt_r;
    assign busy        = (state_r == ST_FILLING);

endmodule
